// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Round-robin arbitration is selected with the MEM_ARB_ROUND_ROBIN_EN macro, evaluated in arb_pick.
package mem_arbiter_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;
  localparam logic [InstBus-1:0] ZeroWord = '0;

  // Byte enables used by every instruction fetch
  localparam logic [3:0] SelWord = 4'hF;

  typedef enum logic [1:0] {
    ArbIdle   = 2'd0,
    ArbBusyIf = 2'd1,
    ArbBusyDm = 2'd2
  } arb_state_e;

  typedef enum logic {
    ArbIdIf = 1'b0,
    ArbIdDm = 1'b1
  } arb_id_e;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner selection between fetch and data-memory requesters.
// MEM_ARB_ROUND_ROBIN_EN defined: conflicts go to the requester that did not win last.
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic    if_elig_i,
  input  logic    dm_elig_i,
  input  arb_id_e last_grant_i,
  output logic    grant_if_o,
  output logic    grant_dm_o
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    grant_dm_o = dm_elig_i & (~if_elig_i | (last_grant_i == ArbIdIf));
    grant_if_o = if_elig_i & ~grant_dm_o;
  end
`else
  // Fixed priority ignores the history flag; the signal below only keeps it visibly consumed.
  logic last_grant_unused;
  assign last_grant_unused = last_grant_i;

  always_comb begin
    grant_dm_o = dm_elig_i;
    grant_if_o = if_elig_i & ~dm_elig_i;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one variable-latency memory port between instruction fetch and data memory.
// Arbitration policy comes from arb_pick (MEM_ARB_ROUND_ROBIN_EN selects round robin).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = InstAddrBus,
  parameter int DATA_W = InstBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_inst,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_sel,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [3:0]        mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  arb_state_e        state_q;
  arb_id_e           last_grant_q;
  logic              if_ack_q;
  logic              dm_ack_q;
  logic [DATA_W-1:0] if_inst_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              mem_ce_q;
  logic              mem_we_q;
  logic [3:0]        mem_sel_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic if_elig;
  logic dm_elig;
  logic grant_if;
  logic grant_dm;

  // A requester whose ack is high this cycle is still finishing its handshake.
  assign if_elig = if_req & ~if_ack_q;
  assign dm_elig = dm_req & ~dm_ack_q;

  // In the fixed-priority build arb_pick ignores last_grant_q, so the flag is pruned away.
  arb_pick u_arb_pick (
    .if_elig_i    (if_elig),
    .dm_elig_i    (dm_elig),
    .last_grant_i (last_grant_q),
    .grant_if_o   (grant_if),
    .grant_dm_o   (grant_dm)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ArbIdle;
      last_grant_q <= ArbIdIf;
      if_ack_q     <= 1'b0;
      dm_ack_q     <= 1'b0;
      if_inst_q    <= '0;
      dm_rdata_q   <= '0;
      mem_ce_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_sel_q    <= 4'h0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      // NOTE: acks default low every cycle so a completion is a single-cycle pulse;
      // non-blocking assignments let the later case branch override this default cleanly.
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      unique case (state_q)
        ArbIdle: begin
          if (grant_dm) begin
            state_q      <= ArbBusyDm;
            last_grant_q <= ArbIdDm;
            mem_ce_q     <= 1'b1;
            mem_we_q     <= dm_we;
            mem_sel_q    <= dm_sel;
            mem_addr_q   <= dm_addr;
            mem_wdata_q  <= dm_wdata;
          end else if (grant_if) begin
            state_q      <= ArbBusyIf;
            last_grant_q <= ArbIdIf;
            mem_ce_q     <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_sel_q    <= SelWord;
            mem_addr_q   <= if_addr;
            mem_wdata_q  <= '0;
          end
        end
        ArbBusyIf: begin
          if (mem_ack) begin
            state_q   <= ArbIdle;
            mem_ce_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            if_ack_q  <= 1'b1;
            if_inst_q <= mem_rdata;
          end
        end
        ArbBusyDm: begin
          if (mem_ack) begin
            state_q  <= ArbIdle;
            mem_ce_q <= 1'b0;
            mem_we_q <= 1'b0;
            dm_ack_q <= 1'b1;
            if (!mem_we_q) dm_rdata_q <= mem_rdata;
          end
        end
        default: begin
          state_q  <= ArbIdle;
          mem_ce_q <= 1'b0;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign if_ack    = if_ack_q;
  assign if_inst   = if_inst_q;
  assign dm_ack    = dm_ack_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_ce    = mem_ce_q;
  assign mem_we    = mem_we_q;
  assign mem_sel   = mem_sel_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
